i2c_slave_regfile: RTL and testbench

Parametrised I2C slave with an internal byte register file, auto-incrementing register pointer and a host-side access port. It is the successor of the fixed slave/driver pair: slave address, register count and pointer width are parameters, and it adds repeated-START, pointer wrap and write-notification strobes. It sits between the board I2C pins and on-chip logic.

---
 rtl/i2c_slave_regfile.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C slave with byte register file, auto-incrementing pointer and host port
// Optional macro I2C_GLITCH_FILTER_EN adds a 3-sample majority filter on scl/sda after the synchroniser.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         NUM_REGS   = 16,
    parameter int         PTR_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire              scl,
    inout  wire              sda,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    input  logic             host_we,
    output logic [7:0]       host_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic [7:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_IGNORE    = 4'd9
    } st_t;

    st_t              st;
    logic [1:0]       scl_s, sda_s;
    logic             scl_f, sda_f, scl_q, sda_q;
    logic             scl_rise, scl_fall, start_det, stop_det;
    logic             sda_oe;
    logic [7:0]       shreg;
    logic [3:0]       bit_cnt;
    logic             rw;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       regs [NUM_REGS];
    logic [7:0]       rx_byte, rd_byte;
    logic             ptr_ok, i2c_we;

    // Synchronisers preset high so an idle bus produces no edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
        end else begin
            scl_s <= {scl_s[0], scl};
            sda_s <= {sda_s[0], sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_h <= 2'b11;
            sda_h <= 2'b11;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_s[1]};
            sda_h <= {sda_h[0], sda_s[1]};
            scl_f <= maj3(scl_h[1], scl_h[0], scl_s[1]);
            sda_f <= maj3(sda_h[1], sda_h[0], sda_s[1]);
        end
    end
`else
    assign scl_f = scl_s[1];
    assign sda_f = sda_s[1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign state   = {4'b0000, st};
    assign rx_byte = {shreg[6:0], sda_f};
    assign rd_byte = regs[ptr];
    assign ptr_ok  = {1'b0, shreg} < 9'(NUM_REGS);
    assign i2c_we  = (st == S_WDATA) && scl_rise && (bit_cnt == 4'd7);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == NUM_REGS - 1) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= S_IDLE;
            sda_oe    <= 1'b0;
            shreg     <= 8'h00;
            bit_cnt   <= 4'd0;
            rw        <= 1'b0;
            ptr       <= '0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                st      <= S_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                st      <= S_IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (st)
                    S_ADDR, S_PTR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (st == S_ADDR) begin
                                if (shreg[7:1] == SLAVE_ADDR) begin
                                    st     <= S_ADDR_ACK;
                                    sda_oe <= 1'b1;
                                    rw     <= shreg[0];
                                    busy   <= 1'b1;
                                end else begin
                                    st <= S_IGNORE;
                                end
                            end else if (ptr_ok) begin
                                ptr    <= shreg[PTR_W-1:0];
                                sda_oe <= 1'b1;
                                st     <= S_PTR_ACK;
                            end else begin
                                st <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                shreg  <= rd_byte;
                                ptr    <= ptr_inc(ptr);
                                sda_oe <= ~rd_byte[7];
                                st     <= S_RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                st     <= S_PTR;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            st     <= S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= rx_byte;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b1;
                            ptr     <= ptr_inc(ptr);
                            st      <= S_WDATA_ACK;
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b0;
                                st      <= S_RDATA_ACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        // A master NACK ends the read immediately; an ACK preloads the next byte.
                        if (scl_rise) begin
                            if (sda_f) st <= S_IGNORE;
                        end else if (scl_fall) begin
                            shreg  <= rd_byte;
                            ptr    <= ptr_inc(ptr);
                            sda_oe <= ~rd_byte[7];
                            st     <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The bus write takes precedence when both ports hit the same register in one clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            host_rdata <= 8'h00;
        end else begin
            if (host_we && (32'(host_addr) < NUM_REGS) && !(i2c_we && (host_addr == ptr)))
                regs[host_addr] <= host_wdata;
            if (i2c_we)
                regs[ptr] <= rx_byte;
            host_rdata <= (32'(host_addr) < NUM_REGS) ? regs[host_addr] : 8'h00;
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - randomized bench for i2c_slave_regfile against a transaction-level register model
module tb_i2c_slave_regfile;
    localparam logic [6:0] SA   = 7'h3C;
    localparam int         NREG = 16;
    localparam int         H    = 12;
`ifdef I2C_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    wire  scl_bus, sda_bus;
    assign scl_bus = m_scl;
    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);

    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wdata = 8'h00;
    logic       host_we = 1'b0;
    logic [7:0] host_rdata, wr_data, state;
    logic [3:0] wr_addr;
    logic       wr_strobe, busy;

    int checks = 0;
    int failures = 0;
    logic [7:0]  mreg [NREG];
    int          mptr = 0;
    logic [11:0] wq [$];
    logic [7:0]  dbuf [8];
    logic [7:0]  rd_last [4];
    bit          glitch_en = 1'b0;
    logic        prev_strobe = 1'b0;

    always #5 clk = ~clk;

    i2c_slave_regfile #(.SLAVE_ADDR(SA), .NUM_REGS(NREG), .PTR_W(4)) dut (
        .clk(clk), .reset(rst_n), .scl(scl_bus), .sda(sda_bus),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we),
        .host_rdata(host_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .state(state)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every write strobe must match the next byte the model expects to land.
    always @(negedge clk) begin : strobe_mon
        logic [11:0] e;
        if (rst_n && wr_strobe) begin
            check("strobe_width", prev_strobe, 0);
            check("strobe_pending", wq.size() > 0, 1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                check("wr_addr", wr_addr, e[11:8]);
                check("wr_data", wr_data, e[7:0]);
            end
        end
        prev_strobe = wr_strobe;
    end

    task automatic m_bit(input logic b, output logic r, input bit collide);
        clk_wait(4); m_sda = b; clk_wait(H - 4); m_scl = 1'b1;
        if (collide) begin
            clk_wait(LAT);
            host_addr = 4'd5; host_wdata = 8'h33; host_we = 1'b1;
            clk_wait(1); host_we = 1'b0;
            clk_wait(H/2 - LAT - 1);
        end else if (glitch_en) begin
            clk_wait(2); m_scl = 1'b0; clk_wait(1); m_scl = 1'b1; clk_wait(H/2 - 3);
        end else begin
            clk_wait(H/2);
        end
        r = sda_bus;
        clk_wait(H/2); m_scl = 1'b0;
    endtask

    task automatic m_start();
        clk_wait(4); m_sda = 1'b1; clk_wait(H - 4); m_scl = 1'b1;
        clk_wait(H/2); m_sda = 1'b0; clk_wait(H/2); m_scl = 1'b0;
    endtask

    task automatic m_stop();
        clk_wait(4); m_sda = 1'b0; clk_wait(H - 4); m_scl = 1'b1;
        clk_wait(H/2); m_sda = 1'b1; clk_wait(H);
    endtask

    task automatic m_byte(input logic [7:0] b, output logic ack, input bit collide);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(b[i], r, collide && i == 0);
        m_bit(1'b1, r, 1'b0);
        ack = !r;
    endtask

    task automatic m_read(output logic [7:0] b, input logic give_ack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r, 1'b0);
            b[i] = r;
        end
        m_bit(!give_ack, r, 1'b0);
    endtask

    task automatic finish_tx();
        m_stop();
        check("busy_after_stop", busy, 0);
        check("state_idle", state, 0);
    endtask

    task automatic tx_write(input logic [6:0] a, input logic [7:0] p, input int n, input bit collide_last);
        logic ack;
        m_start();
        m_byte({a, 1'b0}, ack, 1'b0);
        check("addr_ack", ack, a == SA);
        if (a == SA) begin
            check("busy_set", busy, 1);
            m_byte(p, ack, 1'b0);
            check("ptr_ack", ack, p < NREG);
            if (p < NREG) begin
                mptr = p;
                for (int i = 0; i < n; i++) begin
                    wq.push_back({4'(mptr), dbuf[i]});
                    mreg[mptr] = dbuf[i];
                    m_byte(dbuf[i], ack, collide_last && i == n - 1);
                    check("data_ack", ack, 1);
                    mptr = (mptr + 1) % NREG;
                end
            end
        end else begin
            check("busy_clear", busy, 0);
        end
        finish_tx();
    endtask

    task automatic tx_read(input logic [7:0] p, input bit set_ptr, input int n);
        logic ack;
        logic [7:0] b;
        m_start();
        if (set_ptr) begin
            m_byte({SA, 1'b0}, ack, 1'b0);
            check("addr_w_ack", ack, 1);
            m_byte(p, ack, 1'b0);
            check("rptr_ack", ack, p < NREG);
            if (p >= NREG) begin
                finish_tx();
                return;
            end
            mptr = p;
            m_start();
        end
        m_byte({SA, 1'b1}, ack, 1'b0);
        check("addr_r_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            m_read(b, i != n - 1);
            check("rdata", b, mreg[mptr]);
            rd_last[i] = b;
            mptr = (mptr + 1) % NREG;
        end
        finish_tx();
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        clk_wait(1); host_we = 1'b0;
        mreg[a] = d;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] v);
        host_addr = a; clk_wait(2); v = host_rdata;
    endtask

    task automatic host_scan();
        logic [7:0] v;
        for (int i = 0; i < NREG; i++) begin
            host_read(4'(i), v);
            check("host_rdata", v, mreg[i]);
        end
    endtask

    task automatic mid_reset();
        logic r;
        logic [7:0] a;
        a = {SA, 1'b0};
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(a[i], r, 1'b0);
        m_sda = 1'b1;
        clk_wait(6);
        check("ack_driven", sda_bus, 0);
        check("busy_mid", busy, 1);
        rst_n = 1'b0; #1;
        check("rst_sda", sda_bus, 1);
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_host_rdata", host_rdata, 0);
        for (int i = 0; i < NREG; i++) mreg[i] = 8'h00;
        mptr = 0;
        clk_wait(2); m_scl = 1'b1; clk_wait(2); m_sda = 1'b1; clk_wait(4);
        rst_n = 1'b1; clk_wait(4);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] v;
        for (int i = 0; i < NREG; i++) mreg[i] = 8'h00;
        clk_wait(3);
        check("rst0_host_rdata", host_rdata, 0);
        check("rst0_strobe", wr_strobe, 0);
        check("rst0_wr_addr", wr_addr, 0);
        check("rst0_wr_data", wr_data, 0);
        check("rst0_busy", busy, 0);
        check("rst0_state", state, 0);
        check("rst0_sda", sda_bus, 1);
        rst_n = 1'b1;
        clk_wait(4);
        host_scan();

        dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
        tx_write(SA, 8'h03, 2, 1'b0);
        host_read(4'd3, v); check("reg3_lit", v, 8'hA5);
        host_read(4'd4, v); check("reg4_lit", v, 8'h5A);

        host_write(4'd15, 8'h11);
        host_write(4'd0, 8'h22);
        tx_read(8'h0F, 1'b1, 2);
        check("wrap_rd0_lit", rd_last[0], 8'h11);
        check("wrap_rd1_lit", rd_last[1], 8'h22);

        dbuf[0] = 8'hEE;
        tx_write(7'h3D, 8'h00, 1, 1'b0);
        tx_write(SA, 8'h20, 1, 1'b0);
        host_scan();

        dbuf[0] = 8'h44;
        tx_write(SA, 8'h05, 1, 1'b1);
        host_read(4'd5, v); check("reg5_collide_lit", v, 8'h44);

`ifdef I2C_GLITCH_FILTER_EN
        glitch_en = 1'b1;
        dbuf[0] = 8'hC3;
        tx_write(SA, 8'h09, 1, 1'b0);
        glitch_en = 1'b0;
        host_read(4'd9, v); check("glitch_reg9_lit", v, 8'hC3);
`endif

        repeat (14) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                logic [6:0] a;
                a = ($urandom_range(0, 4) == 0) ? (SA ^ 7'($urandom_range(1, 127))) : SA;
                for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
                tx_write(a, 8'($urandom_range(0, 19)), $urandom_range(1, 4), 1'b0);
            end else if (op == 1) begin
                tx_read(8'($urandom_range(0, 17)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            end else begin
                host_write(4'($urandom_range(0, 15)), 8'($urandom));
            end
        end
        host_scan();

        mid_reset();
        host_scan();
        tx_read(8'h00, 1'b0, 1);

        clk_wait(4);
        check("strobe_queue_empty", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
